// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller: scene and winner codes,
// FSM states and the ability tile encoding.
package game_pkg;

  localparam int FRAMES_PER_SEC_DEF = 60;
  localparam int MAX_TICK_DEF       = 999;
  localparam int NUM_AB_DEF         = 4;

  localparam logic [7:0] SCN_TITLE = 8'd0;
  localparam logic [7:0] SCN_PLAY  = 8'd1;
  localparam logic [7:0] SCN_END   = 8'd2;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  typedef enum logic [1:0] {
    ST_TITLE  = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_PLAY   = 2'd2,
    ST_END    = 2'd3
  } state_t;

  typedef enum logic {
    PRIO_P1 = 1'b0,
    PRIO_P2 = 1'b1
  } prio_t;

  function automatic logic [7:0] ab_onehot(input logic [1:0] idx);
    return 8'h01 << idx;
  endfunction

  function automatic logic ab_valid(input logic [1:0] idx, input int num_ab);
    return int'(idx) < num_ab;
  endfunction

  function automatic logic [7:0] scene_code(input state_t s);
    case (s)
      ST_PLAY: return SCN_PLAY;
      ST_END:  return SCN_END;
      default: return SCN_TITLE;
    endcase
  endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// Player/keyboard-facing signals of the scene sequencer and the colour
// mapper controls it produces.
interface scene_sequencer_if;
  logic        frame_tick;
  logic        start_key;
  logic        p1_req;
  logic [1:0]  p1_req_idx;
  logic        p2_req;
  logic [1:0]  p2_req_idx;
  logic        p1_exit;
  logic        p2_exit;
  logic [7:0]  scene;
  logic [31:0] tick;
  logic [7:0]  p1ab;
  logic [7:0]  p2ab;
  logic [1:0]  winner;
  logic        game_rst;

  modport master (
    output frame_tick, start_key, p1_req, p1_req_idx, p2_req, p2_req_idx,
           p1_exit, p2_exit,
    input  scene, tick, p1ab, p2ab, winner, game_rst
  );

  modport slave (
    input  frame_tick, start_key, p1_req, p1_req_idx, p2_req, p2_req_idx,
           p1_exit, p2_exit,
    output scene, tick, p1ab, p2ab, winner, game_rst
  );
endinterface

// File: rtl/ability_arbiter.sv
// Two-player ability tile allocation: exclusive ownership, re-request moves a
// player's grant, and same-tile contests are settled by a round-robin bit.
module ability_arbiter
  import game_pkg::*;
#(
  parameter int NUM_AB = NUM_AB_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic       p1_req,
  input  logic [1:0] p1_req_idx,
  input  logic       p2_req,
  input  logic [1:0] p2_req_idx,
  output logic [7:0] p1ab,
  output logic [7:0] p2ab
);

  prio_t prio;
  logic  v1, v2, contest, g1, g2;

  // A request survives only if the tile exists and the other player does not own it.
  assign v1      = p1_req && ab_valid(p1_req_idx, NUM_AB) && !p2ab[p1_req_idx];
  assign v2      = p2_req && ab_valid(p2_req_idx, NUM_AB) && !p1ab[p2_req_idx];
  assign contest = v1 && v2 && (p1_req_idx == p2_req_idx);
  assign g1      = v1 && !(contest && prio == PRIO_P2);
  assign g2      = v2 && !(contest && prio == PRIO_P1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1ab <= '0;
      p2ab <= '0;
      prio <= PRIO_P1;
    end else if (clear) begin
      p1ab <= '0;
      p2ab <= '0;
    end else if (enable) begin
      if (g1) p1ab <= ab_onehot(p1_req_idx);
      if (g2) p2ab <= ab_onehot(p2_req_idx);
      if (contest) prio <= (prio == PRIO_P1) ? PRIO_P2 : PRIO_P1;
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// Game-flow controller: title/ability select, launch pulse, seconds timer
// during play and the end-screen hold, driving the colour mapper.
module scene_sequencer
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = FRAMES_PER_SEC_DEF,
  parameter int MAX_TICK       = MAX_TICK_DEF,
  parameter int NUM_AB         = NUM_AB_DEF
) (
  input logic               Clk,
  input logic               Reset_n,
  scene_sequencer_if.slave  bus
);

  localparam int FCW = $clog2(FRAMES_PER_SEC);

  state_t          state, state_nx;
  logic            start_q, start_go;
  logic [FCW-1:0]  fcnt;
  logic [31:0]     tick;
  logic [1:0]      winner, winner_nx;
  logic [7:0]      scene_r, scene_nx;
  logic            game_rst_r, game_rst_nx;
  logic [7:0]      p1ab_w, p2ab_w;
  logic            any_exit, sec_wrap, timeout;

  assign start_go = bus.start_key & ~start_q;
  assign any_exit = bus.p1_exit | bus.p2_exit;
  assign sec_wrap = bus.frame_tick && (fcnt == FCW'(FRAMES_PER_SEC - 1));
  assign timeout  = (tick >= 32'(MAX_TICK)) ||
                    (sec_wrap && tick >= 32'(MAX_TICK - 1));

  ability_arbiter #(.NUM_AB(NUM_AB)) u_arb (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .enable     (state == ST_TITLE),
    .clear      (state == ST_END && start_go),
    .p1_req     (bus.p1_req),
    .p1_req_idx (bus.p1_req_idx),
    .p2_req     (bus.p2_req),
    .p2_req_idx (bus.p2_req_idx),
    .p1ab       (p1ab_w),
    .p2ab       (p2ab_w)
  );

  // NOTE: reset is synchronous, so it lives inside the clocked block and is
  // only seen at a Clk edge; every register here is reset, none is a memory.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= ST_TITLE;
    else          state <= state_nx;
  end

  // NOTE: combinational blocks assign a default first so no path holds a value (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      ST_TITLE:  if (start_go && p1ab_w != '0 && p2ab_w != '0) state_nx = ST_LAUNCH;
      ST_LAUNCH: state_nx = ST_PLAY;
      ST_PLAY:   if (any_exit || timeout) state_nx = ST_END;
      ST_END:    if (start_go) state_nx = ST_TITLE;
      default:   state_nx = ST_TITLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so they settle on the edge.
  always_comb begin
    scene_nx    = scene_code(state_nx);
    game_rst_nx = (state_nx == ST_LAUNCH);
    winner_nx   = winner;
    case (state)
      ST_TITLE: if (state_nx == ST_LAUNCH) winner_nx = WIN_NONE;
      ST_PLAY: begin
        if (bus.p1_exit && bus.p2_exit) winner_nx = WIN_TIE;
        else if (bus.p1_exit)           winner_nx = WIN_P1;
        else if (bus.p2_exit)           winner_nx = WIN_P2;
        else if (timeout)               winner_nx = WIN_NONE;
      end
      ST_END: if (start_go) winner_nx = WIN_NONE;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      start_q    <= 1'b0;
      fcnt       <= '0;
      tick       <= '0;
      winner     <= WIN_NONE;
      scene_r    <= SCN_TITLE;
      game_rst_r <= 1'b0;
    end else begin
      start_q    <= bus.start_key;
      winner     <= winner_nx;
      scene_r    <= scene_nx;
      game_rst_r <= game_rst_nx;
      if (state_nx == ST_LAUNCH) begin
        fcnt <= '0;
        tick <= '0;
      end else if (state == ST_PLAY && !any_exit && bus.frame_tick) begin
        if (sec_wrap) begin
          fcnt <= '0;
          tick <= timeout ? 32'(MAX_TICK) : tick + 32'd1;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  assign bus.scene    = scene_r;
  assign bus.tick     = tick;
  assign bus.p1ab     = p1ab_w;
  assign bus.p2ab     = p2ab_w;
  assign bus.winner   = winner;
  assign bus.game_rst = game_rst_r;

endmodule
